// File: rtl/mult_div_seq.sv
// mult_div_seq
//   Iterative multiply/divide unit for the Hi/Lo register pair of the
//   multicycle CPU. One operation takes WIDTH+1 cycles from the start edge
//   to the done pulse. This latency is the same for all four ops and for
//   divide by zero.
//
//   Ports
//     clk       in   rising-edge clock
//     reset     in   asynchronous, active-low reset
//     start     in   operation request, sampled only while idle
//     op        in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     a, b      in   multiplicand/dividend, multiplier/divisor
//     busy      out  operation in progress
//     done      out  one-cycle pulse when hi/lo (or div_zero) are valid
//     div_zero  out  one-cycle pulse with done for DIV/DIVU with b==0
//     hi, lo    out  product high/low, or remainder/quotient
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 div_zero_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 is_div_q;   // 1: divide, 0: multiply
    logic                 neg_res_q;  // negate product / quotient at FIN
    logic                 neg_rem_q;  // negate remainder at FIN
    logic                 dz_q;       // divisor was zero
    logic [WIDTH-1:0]     opnd_q;     // |multiplicand| or |divisor|
    logic [2*WIDTH-1:0]   acc_q;      // {partial product, multiplier} or {remainder, quotient}
    logic [CW-1:0]        cnt_q;

    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     hi_d;
    logic [WIDTH-1:0]     lo_d;

    // Magnitude of a possibly signed operand. The most negative value maps
    // onto itself, which is exactly 2^(W-1) when read as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                             input logic             sgn);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x,
                                               input logic             n);
        return n ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x,
                                                  input logic               n);
        return n ? (~x + 1'b1) : x;
    endfunction

    // One iteration of the datapath.
    //   Multiply: conditional add of the multiplicand into the upper half,
    //   then a right shift of the whole accumulator. The add carry becomes
    //   the new top bit.
    //   Divide (restoring): shift the next dividend bit into the remainder,
    //   then try to subtract the divisor. A non-negative difference is kept
    //   and yields a 1 quotient bit in the vacated LSB.
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_trial;
    logic [WIDTH:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opnd_q};
        acc_d     = acc_q;
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction of the final accumulator
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        prod_fix = neg_2w(acc_q, neg_res_q);
        hi_d     = prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            hi_d = neg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
            lo_d = neg_w(acc_q[WIDTH-1:0], neg_res_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // op[0]==0 selects the signed variants
                        is_div_q  <= op[1];
                        neg_res_q <= ~op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_q <= ~op[0] & a[WIDTH-1];
                        dz_q      <= op[1] & (b == '0);
                        if (op[1]) begin
                            opnd_q <= mag(b, ~op[0]);
                            acc_q  <= {{WIDTH{1'b0}}, mag(a, ~op[0])};
                        end else begin
                            opnd_q <= mag(a, ~op[0]);
                            acc_q  <= {{WIDTH{1'b0}}, mag(b, ~op[0])};
                        end
                        cnt_q   <= CW'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    // Divide by zero leaves the previous hi/lo in place
                    if (!dz_q) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
                    div_zero_q <= dz_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq
//   Directed bench for mult_div_seq: a 32-bit instance driven from a vector
//   table, plus an 8-bit instance for back-to-back operation.
module tb_mult_div_seq;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, div_zero8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;

    mult_div_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    mult_div_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present an op for one edge (E0), then scramble the operand inputs.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom);
    endtask

    // Count edges after E0 until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
    endtask

    initial begin
        int cyc;
        int pulses;

        vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{DIVU,  32'd35,       32'd6,        32'd5,        32'd5,        1'b0};
        vecs[6]  = '{DIVU,  32'd100,      32'd0,        32'd5,        32'd5,        1'b1};
        vecs[7]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[9]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[10] = '{DIV,   32'd100,      32'd0,        32'h40000000, 32'h00000000, 1'b1};
        vecs[11] = '{MULT,  32'd5,        32'd0,        32'h00000000, 32'h00000000, 1'b0};
        vecs[12] = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dz",   64'(div_zero), 64'd0);
        check("reset_hi",   64'(hi), 64'd0);
        check("reset_lo",   64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven operations
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
            wait_done(cyc);
            check($sformatf("v%0d_latency", i), 64'(cyc), 64'd33);
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            check($sformatf("v%0d_dz", i), 64'(div_zero), 64'(vecs[i].dz));
            check($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
            check($sformatf("v%0d_dz_pulse", i), 64'(div_zero), 64'd0);
        end

        // start while busy is ignored
        issue(DIVU, 32'd100, 32'd7);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 10) begin
                start = 1'b1; op = MULTU; a = 32'd3; b = 32'd3;
            end
            if (cyc == 11) start = 1'b0;
            if (done) break;
        end
        check("busy_start_latency", 64'(cyc), 64'd33);
        check("busy_start_hi", 64'(hi), 64'd2);
        check("busy_start_lo", 64'(lo), 64'd14);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("busy_start_no_second_done", 64'(pulses), 64'd0);

        // Asynchronous reset mid-divide with a re-pulsed start
        issue(DIV, 32'd1000, 32'd3);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 8) begin
                start = 1'b1; op = MULTU; a = 32'd9; b = 32'd9;
            end
            if (c == 9) start = 1'b0;
        end
        #2;
        reset = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_hi", 64'(hi), 64'd0);
        check("midreset_lo", 64'(lo), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        check("postreset_idle", 64'(pulses), 64'd0);
        issue(MULTU, 32'd6, 32'd7);
        wait_done(cyc);
        check("postreset_latency", 64'(cyc), 64'd33);
        check("postreset_hi", 64'(hi), 64'd0);
        check("postreset_lo", 64'(lo), 64'd42);

        // WIDTH=8: back-to-back MULTU then DIVU started in the done cycle
        @(negedge clk);
        op8 = MULTU; a8 = 8'd15; b8 = 8'd17; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done8) break;
        end
        check("w8_mul_latency", 64'(cyc), 64'd9);
        check("w8_mul_hi", 64'(hi8), 64'h00);
        check("w8_mul_lo", 64'(lo8), 64'hFF);
        check("w8_busy_at_done", 64'(busy8), 64'd0);
        op8 = DIVU; a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'd1; b8 = 8'd1;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done8) break;
        end
        check("w8_div_latency", 64'(cyc), 64'd9);
        check("w8_div_hi", 64'(hi8), 64'h04);
        check("w8_div_lo", 64'(lo8), 64'h1C);
        check("w8_div_dz", 64'(div_zero8), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
